// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - op, select and FSM encodings shared by the shift sequencer
package shift_pkg;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  localparam logic [1:0] SEL_PASS  = 2'd0;
  localparam logic [1:0] SEL_RIGHT = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Only LSL moves left; every other op is a right shift differing in fill bit.
  function automatic logic [1:0] op_select(input logic [1:0] op);
    return (op == OP_LSL) ? SEL_LEFT : SEL_RIGHT;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result handshake bundle; Carry exists only with SHIFT_CARRY_OUT_EN
interface shift_sequencer_if #(
  parameter int BITS = 16,
  parameter int AMTW = 4
);
  logic            InValid;
  logic            InReady;
  logic [1:0]      Op;
  logic [AMTW-1:0] Amount;
  logic [BITS-1:0] A;
  logic            OutValid;
  logic            OutReady;
  logic [BITS-1:0] Result;
  logic            Busy;
`ifdef SHIFT_CARRY_OUT_EN
  logic            Carry;
`endif

  modport master (
    output InValid, Op, Amount, A, OutReady,
`ifdef SHIFT_CARRY_OUT_EN
    input  Carry,
`endif
    input  InReady, OutValid, Result, Busy
  );

  modport slave (
    input  InValid, Op, Amount, A, OutReady,
`ifdef SHIFT_CARRY_OUT_EN
    output Carry,
`endif
    output InReady, OutValid, Result, Busy
  );

endinterface

// File: rtl/shift_sequencer_shift1_stage.sv
// rtl/shift_sequencer_shift1_stage.sv - combinational 1-bit shift stage (pass/right/left)
module shift1_stage
  import shift_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic [1:0]      Select,
  input  logic            InL,
  input  logic            InR,
  input  logic [BITS-1:0] B,
  output logic [BITS-1:0] HOut
);

  always_comb begin
    HOut = B;
    case (Select)
      SEL_RIGHT: HOut = {InL, B[BITS-1:1]};
      SEL_LEFT:  HOut = {B[BITS-2:0], InR};
      default:   HOut = B;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - one-bit-per-clock shift controller; SHIFT_CARRY_OUT_EN adds the Carry output
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int BITS = 16,
  parameter int AMTW = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  shift_sequencer_if.slave   bus
);

  logic [1:0]      state_q;
  logic [1:0]      op_q;
  logic [AMTW-1:0] count_q;
  logic [BITS-1:0] data_q;
  logic [BITS-1:0] data_shifted;
  logic [1:0]      sel;
  logic            in_l;
  logic            in_r;
  logic            accept;

  assign accept = (state_q == ST_IDLE) && bus.InValid;

  always_comb begin
    sel  = op_select(op_q);
    in_l = 1'b0;
    in_r = 1'b0;
    case (op_q)
      OP_ASR:  in_l = data_q[BITS-1];
      OP_ROR:  in_l = data_q[0];
      default: in_l = 1'b0;
    endcase
  end

  shift1_stage #(.BITS(BITS)) u_stage (
    .Select (sel),
    .InL    (in_l),
    .InR    (in_r),
    .B      (data_q),
    .HOut   (data_shifted)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LSL;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= bus.A;
            op_q    <= bus.Op;
            count_q <= bus.Amount;
            state_q <= (bus.Amount == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The last shift and the move to DONE share an edge.
          data_q  <= data_shifted;
          count_q <= count_q - AMTW'(1);
          if (count_q == AMTW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.OutReady) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFT_CARRY_OUT_EN
  logic carry_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      carry_q <= (op_q == OP_LSL) ? data_q[BITS-1] : data_q[0];
    end
  end

  assign bus.Carry = carry_q;
`endif

  assign bus.InReady  = (state_q == ST_IDLE);
  assign bus.OutValid = (state_q == ST_DONE);
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Result   = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed vector bench for shift_sequencer
module tb_shift_sequencer;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] a;
    logic [15:0] res;
    logic        cy;
  } vec_t;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;
  vec_t vecs[10];

  shift_sequencer_if #(.BITS(16), .AMTW(4)) bus ();

  shift_sequencer #(.BITS(16), .AMTW(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] a);
    int n = 0;
    while (bus.InReady !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue in_ready", {31'd0, bus.InReady}, 32'd1);
    bus.InValid = 1'b1;
    bus.Op      = op;
    bus.Amount  = amt;
    bus.A       = a;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
  endtask

  // Entered #1 after the accept edge; counts edges until OutValid, then drains.
  task automatic collect(input string name, input logic [15:0] exp_res, input int exp_lat,
                         input logic exp_cy);
    int n = 0;
    while (bus.OutValid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " result"}, {16'd0, bus.Result}, {16'd0, exp_res});
`ifdef SHIFT_CARRY_OUT_EN
    check({name, " carry"}, {31'd0, bus.Carry}, {31'd0, exp_cy});
`else
    if (exp_cy === 1'bx) $display("note: unknown carry expectation in %s", name);
`endif
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    bus.OutReady = 1'b0;
    check({name, " out_valid drop"}, {31'd0, bus.OutValid}, 32'd0);
    check({name, " in_ready back"}, {31'd0, bus.InReady}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{LSL, 4'd15, 16'h0001, 16'h8000, 1'b0};
    vecs[1] = '{ASR, 4'd4,  16'h8000, 16'hF800, 1'b0};
    vecs[2] = '{LSR, 4'd4,  16'h8000, 16'h0800, 1'b0};
    vecs[3] = '{ROR, 4'd1,  16'h0003, 16'h8001, 1'b1};
    vecs[4] = '{ROR, 4'd0,  16'h0003, 16'h0003, 1'b0};
    vecs[5] = '{LSL, 4'd4,  16'h1234, 16'h2340, 1'b1};
    vecs[6] = '{ROR, 4'd4,  16'h1234, 16'h4123, 1'b0};
    vecs[7] = '{ASR, 4'd15, 16'h7FFF, 16'h0000, 1'b1};
    vecs[8] = '{LSR, 4'd15, 16'hFFFF, 16'h0001, 1'b1};
    vecs[9] = '{LSL, 4'd1,  16'hFFFF, 16'hFFFE, 1'b1};

    nrst         = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    bus.Op       = 2'd0;
    bus.Amount   = 4'd0;
    bus.A        = 16'd0;
    @(posedge clk); #1;
    check("reset in_ready",  {31'd0, bus.InReady},  32'd1);
    check("reset out_valid", {31'd0, bus.OutValid}, 32'd0);
    check("reset busy",      {31'd0, bus.Busy},     32'd0);
    check("reset result",    {16'd0, bus.Result},   32'd0);
`ifdef SHIFT_CARRY_OUT_EN
    check("reset carry",     {31'd0, bus.Carry},    32'd0);
`endif
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].a);
      collect($sformatf("vec%0d", i), vecs[i].res, int'(vecs[i].amt), vecs[i].cy);
    end

    // Asynchronous reset three shifts into LSL 0x0001 by 8.
    issue(LSL, 4'd8, 16'h0001);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort mid result", {16'd0, bus.Result}, 32'h0008);
    nrst = 1'b0;
    #1;
    check("abort out_valid", {31'd0, bus.OutValid}, 32'd0);
    check("abort in_ready",  {31'd0, bus.InReady},  32'd1);
    check("abort result",    {16'd0, bus.Result},   32'd0);
    check("abort busy",      {31'd0, bus.Busy},     32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    issue(LSL, 4'd8, 16'h0001);
    collect("after abort", 16'h0100, 8, 1'b0);

    // Back-pressure with a request waiting on the input side.
    issue(LSL, 4'd2, 16'h0003);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("bp out_valid", {31'd0, bus.OutValid}, 32'd1);
    bus.InValid = 1'b1;
    bus.Op      = LSR;
    bus.Amount  = 4'd4;
    bus.A       = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold result",    {16'd0, bus.Result},   32'h000C);
      check("bp hold out_valid", {31'd0, bus.OutValid}, 32'd1);
      check("bp hold in_ready",  {31'd0, bus.InReady},  32'd0);
    end
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    bus.OutReady = 1'b0;
    check("bp release out_valid", {31'd0, bus.OutValid}, 32'd0);
    check("bp release in_ready",  {31'd0, bus.InReady},  32'd1);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    check("bp pending busy",     {31'd0, bus.Busy},    32'd1);
    check("bp pending in_ready", {31'd0, bus.InReady}, 32'd0);
    collect("bp pending", 16'h00F0, 4, 1'b0);

    // Inputs toggled while shifting, OutReady high before OutValid.
    issue(ROR, 4'd4, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      bus.A        = ~bus.A;
      bus.Op       = bus.Op + 2'd1;
      bus.Amount   = bus.Amount + 4'd1;
      bus.OutReady = 1'b1;
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b0;
    check("toggle out_valid", {31'd0, bus.OutValid}, 32'd1);
    collect("toggle", 16'h4123, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
